// File: rtl/ssd_scan_ctrl_if.sv
// rtl/ssd_scan_ctrl_if.sv - display scan bundle between display source and scan controller
interface ssd_scan_ctrl_if;
   logic        en;
   logic [15:0] value;
   logic        s0;
   logic        s1;
   logic [3:0]  dig0;
   logic [3:0]  dig1;
   logic [3:0]  dig2;
   logic [3:0]  dig3;
   logic [3:0]  an;
   logic        frame_tick;

   // Side that supplies the value and enable and observes the scan outputs
   modport master (
      output en, value,
      input  s0, s1, dig0, dig1, dig2, dig3, an, frame_tick
   );

   // Scan controller side
   modport slave (
      input  en, value,
      output s0, s1, dig0, dig1, dig2, dig3, an, frame_tick
   );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - 4-digit seven-segment scan controller (optional SSD_LZB_EN leading-zero blanking)
module ssd_scan_ctrl #(
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 1000,
   parameter int CW       = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   ssd_scan_ctrl_if.slave io_scan
);

   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nxt;
   logic [1:0]         r_idx;
   logic [1:0]         w_idx_nxt;
   logic [15:0]        r_shadow;
   logic [15:0]        w_shadow_nxt;
   logic [1:0]         r_sel;
   logic [1:0]         w_sel_nxt;
   logic [3:0]         r_an;
   logic [3:0]         w_an_nxt;
   logic               r_tick;
   logic               w_tick_nxt;
   logic               w_wrap;
   logic               w_frame;
   logic               w_lzb;
   logic signed [31:0] w_cnt_ext;

   // State register: counters, shadow and all registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_idx    <= 2'd0;
         r_shadow <= 16'h0000;
         r_sel    <= 2'd0;
         r_an     <= 4'hF;
         r_tick   <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_idx    <= w_idx_nxt;
         r_shadow <= w_shadow_nxt;
         r_sel    <= w_sel_nxt;
         r_an     <= w_an_nxt;
         r_tick   <= w_tick_nxt;
      end
   end

   // Next-state: prescale count, digit index and frame-boundary shadow reload; all hold while disabled
   always_comb begin
      w_wrap    = (r_cnt == CW'(PRESCALE - 1));
      w_cnt_nxt = r_cnt;
      w_idx_nxt = r_idx;
      w_frame   = 1'b0;
      if (io_scan.en) begin
         if (w_wrap) begin
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + 2'd1;
            w_frame   = (r_idx == 2'd3);
         end else begin
            w_cnt_nxt = r_cnt + CW'(1);
         end
      end
      w_shadow_nxt = w_frame ? io_scan.value : r_shadow;
   end

`ifdef SSD_LZB_EN
   // Leading-zero blanking of the digit about to be shown, judged on the frame's shadow value
   always_comb begin
      w_lzb = 1'b0;
      case (w_idx_nxt)
         2'd3:    w_lzb = (w_shadow_nxt[15:12] == 4'h0);
         2'd2:    w_lzb = (w_shadow_nxt[15:8]  == 8'h00);
         2'd1:    w_lzb = (w_shadow_nxt[15:4]  == 12'h000);
         default: w_lzb = 1'b0;
      endcase
   end
`else
   assign w_lzb = 1'b0;
`endif

   // Output decode from next-state count/index so select and anodes always name the same digit
   always_comb begin
      w_cnt_ext  = signed'(32'(w_cnt_nxt));
      w_sel_nxt  = w_idx_nxt;
      w_tick_nxt = w_frame;
      if (!io_scan.en || (w_cnt_ext < BLANK) || w_lzb) begin
         w_an_nxt = 4'hF;
      end else begin
         w_an_nxt = ~(4'b0001 << w_idx_nxt);
      end
   end

   assign io_scan.s0         = r_sel[0];
   assign io_scan.s1         = r_sel[1];
   assign io_scan.an         = r_an;
   assign io_scan.frame_tick = r_tick;
   assign io_scan.dig0       = r_shadow[3:0];
   assign io_scan.dig1       = r_shadow[7:4];
   assign io_scan.dig2       = r_shadow[11:8];
   assign io_scan.dig3       = r_shadow[15:12];

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit seven-segment display, one stage upstream of the digit-select 4:1 mux.
- Divides the system clock into per-digit slots and walks a digit index 0->1->2->3->0.
- Drives the mux select lines S1/S0 and the active-low digit anodes.
- Latches the 16-bit display value once per frame into a shadow register, so the four digits never tear.
- Presents the latched value to the mux as four nibbles.

Parameters:
PRESCALE, 50000, clock cycles per digit slot; legal range 4..65535.
BLANK, 1000, dead-time cycles at the start of each slot with all anodes off (anti-ghosting); must satisfy 0 <= BLANK < PRESCALE.
CW, 16, prescale counter width; must hold PRESCALE-1.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Resetn  input  1  asynchronous, active-low reset.
En  input  1  scan enable; when low, counters freeze and display is dark.
Value  input  16  hex value to display; Value[3:0] is digit 0 (rightmost).
S0  output  1  mux select LSB = digit index bit 0.
S1  output  1  mux select MSB = digit index bit 1.
Dig0  output  4  shadow[3:0]; feeds mux W0..Z0 (W = bit 3).
Dig1  output  4  shadow[7:4]; feeds mux W1..Z1.
Dig2  output  4  shadow[11:8]; feeds mux W2..Z2.
Dig3  output  4  shadow[15:12]; feeds mux W3..Z3.
AN  output  4  active-low anode enables; AN[i] low lights digit i.
Frame_Tick  output  1  one-cycle pulse when a new frame starts and shadow has reloaded.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (Resetn); deassertion takes effect on the next Clock edge.
- Reset values: prescale count = 0, index = 0, S1S0 = 00, AN = 4'b1111, Frame_Tick = 0, shadow = 16'h0000 (Dig0..Dig3 = 0).
- All outputs are registered. S1S0 and AN are computed from the next-state count and index, so in any given cycle S1S0 and AN always refer to the same digit.
- Prescale counter (En high):
  - Counts 0..PRESCALE-1.
  - At PRESCALE-1 it wraps to 0, and index increments modulo 4.
- Frame boundary: the cycle in which index wraps 3->0.
  - shadow <= Value, sampled on that edge.
  - Frame_Tick is high for exactly the following cycle, which is the first cycle of the digit-0 slot (count = 0).
- Shadow register: loads only at a frame boundary. Value changes mid-frame have no visible effect until the next frame. The first frame after reset shows 0000.
- Anode decode: AN = 1111 when any of the following hold:
  - count < BLANK;
  - En is low;
  - the digit is blanked by the optional feature.
  Otherwise AN = ~(1 << index).
- En low:
  - Count, index and shadow hold.
  - AN is forced to 1111 on the next edge.
  - Frame_Tick stays 0.
  - On re-enable, counting resumes from the held count and index.
- Slot timing: each digit is lit for exactly PRESCALE-BLANK cycles per slot; one frame is 4*PRESCALE cycles.
- Reset mid-slot: all state returns to reset values immediately, with no partial Frame_Tick.
- Simultaneous events: En falling on the frame-boundary edge suppresses that wrap; the shadow is not loaded and Frame_Tick is not pulsed.

Optional Feature:
Macro SSD_LZB_EN enables leading-zero blanking, evaluated on the shadow register.
- With SSD_LZB_EN defined:
  - Digit 3 is blanked when shadow[15:12] == 0.
  - Digit 2 is blanked when shadow[15:8] == 0.
  - Digit 1 is blanked when shadow[15:4] == 0.
  - Digit 0 is never blanked.
  - Blanked digits keep AN = 1111 for their whole slot. Index, S1S0 and timing are unchanged.
- Without the macro: all four digits light every frame; no blanking logic is synthesised.

Test Plan:
1. Reset and scan order, PRESCALE=8, BLANK=2, En=1, Value=16'h1234: assert Resetn=0 mid-run -> S1S0=00, AN=1111 and Frame_Tick=0 immediately. After release, S1S0 steps 00,01,10,11 every 8 cycles; AN is 1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles each.
2. Frame latch: Value=16'h1234, change to 16'hABCD during the digit-2 slot -> Dig3..Dig0 stay 1,2,3,4 until the 3->0 wrap. Then they show A,B,C,D, and Frame_Tick pulses once, aligned to the first digit-0 cycle.
3. Enable freeze: drop En for 20 cycles in the middle of the digit-1 slot (count=5) -> AN=1111 the next cycle, count and S1S0 frozen. On re-enable, the digit-1 slot completes its remaining cycles.
4. Boundary config: PRESCALE=4, BLANK=0 -> an anode is active every cycle and frame period = 16 cycles.
5. SSD_LZB_EN defined, Value=16'h0042 -> AN never lows digits 3 and 2; digits 1 and 0 light normally. With Value=16'h0000, only digit 0 lights.
6. Same as case 5 with SSD_LZB_EN undefined -> all four digits light showing 0,0,4,2.
